// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, overflow/underflow pulses and an optional first-word-fall-through read port.
module fifo_param #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AW       = $clog2(DEPTH),
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter bit          FWFT     = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [AW:0]      count,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);
   localparam logic [AW:0] AfLevel  = (AW + 1)'(AF_LEVEL);
   localparam logic [AW:0] AeLevel  = (AW + 1)'(AE_LEVEL);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic        full_q, full_d;
   logic        empty_q, empty_d;
   logic        af_q, af_d;
   logic        ae_q, ae_d;
   logic        ov_q, ov_d;
   logic        un_q, un_d;

   logic rd_ok;
   logic wr_ok;

   // A full FIFO may still take a write when the head is popped on the same edge.
   assign rd_ok = rd_en & ~empty_q;
   assign wr_ok = wr_en & (~full_q | rd_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Occupancy is the modulo-2^(AW+1) pointer distance; the wrap bit disambiguates full/empty.
   always_comb begin
      count_d = wr_ptr_d - rd_ptr_d;
      full_d  = (count_d == DepthCnt);
      empty_d = (count_d == '0);
      af_d    = (count_d >= AfLevel);
      ae_d    = (count_d <= AeLevel);
      ov_d    = wr_en & ~wr_ok;
      un_d    = rd_en & ~rd_ok;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ov_q     <= 1'b0;
         un_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ov_q     <= ov_d;
         un_q     <= un_d;
      end
   end

   // Storage is never cleared; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (wr_ok && !reset) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

   if (FWFT) begin : g_fwft
      assign dout = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end else begin : g_std
      logic [WIDTH-1:0] dout_q, dout_d;

      always_comb begin
         dout_d = dout_q;
         if (rd_ok) begin
            dout_d = mem_q[rd_ptr_q[AW-1:0]];
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            dout_q <= '0;
         end else begin
            dout_q <= dout_d;
         end
      end

      assign dout = dout_q;
   end

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = ov_q;
   assign underflow    = un_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: table-driven fill/drain on a standard-mode instance,
// hand-written sequences for simultaneous access, resets and FWFT mode.
module tb_fifo_param;

   logic clk = 1'b0;
   logic reset;

   logic [15:0] din_s, dout_s;
   logic        wr_s, rd_s, full_s, empty_s, af_s, ae_s, ov_s, un_s;
   logic [4:0]  count_s;

   logic [15:0] din_f, dout_f;
   logic        wr_f, rd_f, full_f, empty_f, af_f, ae_f, ov_f, un_f;
   logic [4:0]  count_f;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [15:0] din;
      logic [15:0] dout;
      logic [4:0]  cnt;
      logic        full;
      logic        empty;
      logic        af;
      logic        ae;
      logic        ov;
      logic        un;
   } vec_t;

   vec_t        vecs [34];
   logic [15:0] model_q [$];
   logic [15:0] exp_d;

   always #5 clk = ~clk;

   fifo_param #(.WIDTH(16), .DEPTH(16), .FWFT(1'b0)) u_std (
      .clk         (clk),
      .reset       (reset),
      .din         (din_s),
      .wr_en       (wr_s),
      .rd_en       (rd_s),
      .dout        (dout_s),
      .full        (full_s),
      .empty       (empty_s),
      .almost_full (af_s),
      .almost_empty(ae_s),
      .count       (count_s),
      .overflow    (ov_s),
      .underflow   (un_s)
   );

   fifo_param #(.WIDTH(16), .DEPTH(16), .FWFT(1'b1)) u_fwft (
      .clk         (clk),
      .reset       (reset),
      .din         (din_f),
      .wr_en       (wr_f),
      .rd_en       (rd_f),
      .dout        (dout_f),
      .full        (full_f),
      .empty       (empty_f),
      .almost_full (af_f),
      .almost_empty(ae_f),
      .count       (count_f),
      .overflow    (ov_f),
      .underflow   (un_f)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic vec_t mk(input logic wr, input logic rd, input logic [15:0] din,
                               input logic [15:0] dout, input int cnt, input logic ov,
                               input logic un);
      vec_t v;
      v.wr    = wr;
      v.rd    = rd;
      v.din   = din;
      v.dout  = dout;
      v.cnt   = 5'(cnt);
      v.full  = (cnt == 16);
      v.empty = (cnt == 0);
      v.af    = (cnt >= 14);
      v.ae    = (cnt <= 2);
      v.ov    = ov;
      v.un    = un;
      return v;
   endfunction

   task automatic check_std(input string tag, input vec_t v);
      chk({tag, " dout"},  32'(dout_s),  32'(v.dout));
      chk({tag, " count"}, 32'(count_s), 32'(v.cnt));
      chk({tag, " full"},  32'(full_s),  32'(v.full));
      chk({tag, " empty"}, 32'(empty_s), 32'(v.empty));
      chk({tag, " afull"}, 32'(af_s),    32'(v.af));
      chk({tag, " aempty"},32'(ae_s),    32'(v.ae));
      chk({tag, " ovf"},   32'(ov_s),    32'(v.ov));
      chk({tag, " unf"},   32'(un_s),    32'(v.un));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Fill 16, overflow on the 17th, drain 16, underflow on the 17th.
      for (int i = 0; i < 16; i++) begin
         vecs[i] = mk(1'b1, 1'b0, 16'h0017 + 16'(i), 16'h0000, i + 1, 1'b0, 1'b0);
      end
      vecs[16] = mk(1'b1, 1'b0, 16'h0027, 16'h0000, 16, 1'b1, 1'b0);
      for (int k = 0; k < 16; k++) begin
         vecs[17 + k] = mk(1'b0, 1'b1, 16'h0000, 16'h0017 + 16'(k), 15 - k, 1'b0, 1'b0);
      end
      vecs[33] = mk(1'b0, 1'b1, 16'h0000, 16'h0026, 0, 1'b0, 1'b1);

      reset = 1'b1;
      {wr_s, rd_s, wr_f, rd_f} = '0;
      din_s = '0;
      din_f = '0;
      #12;
      check_std("reset", mk(1'b0, 1'b0, 16'h0, 16'h0, 0, 1'b0, 1'b0));
      chk("reset fwft count", 32'(count_f), 32'd0);
      chk("reset fwft empty", 32'(empty_f), 32'd1);
      reset = 1'b0;

      for (int i = 0; i < 34; i++) begin
         wr_s  = vecs[i].wr;
         rd_s  = vecs[i].rd;
         din_s = vecs[i].din;
         tick();
         check_std($sformatf("vec%0d", i), vecs[i]);
      end
      {wr_s, rd_s} = '0;

      // Refill, then 40 cycles of simultaneous read+write at full.
      for (int i = 0; i < 16; i++) begin
         wr_s  = 1'b1;
         din_s = 16'h0100 + 16'(i);
         model_q.push_back(din_s);
         tick();
      end
      chk("refill count", 32'(count_s), 32'd16);
      rd_s = 1'b1;
      for (int j = 0; j < 40; j++) begin
         din_s = 16'h0200 + 16'(j);
         tick();
         exp_d = model_q.pop_front();
         model_q.push_back(din_s);
         check_std($sformatf("simul%0d", j), mk(1'b1, 1'b1, din_s, exp_d, 16, 1'b0, 1'b0));
      end
      wr_s = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         exp_d = model_q.pop_front();
         chk($sformatf("postwrap%0d dout", k), 32'(dout_s), 32'(exp_d));
      end
      chk("postwrap empty", 32'(empty_s), 32'd1);

      // Empty with both requests: write taken, read rejected.
      wr_s  = 1'b1;
      din_s = 16'h0055;
      tick();
      check_std("empty both", mk(1'b1, 1'b1, 16'h0055, exp_d, 1, 1'b0, 1'b1));
      wr_s = 1'b0;
      tick();
      check_std("empty both pop", mk(1'b0, 1'b1, 16'h0, 16'h0055, 0, 1'b0, 1'b0));
      rd_s = 1'b0;

      // Asynchronous reset mid-cycle, no clock edge in the window.
      for (int i = 0; i < 3; i++) begin
         wr_s  = 1'b1;
         din_s = 16'h0031 + 16'(i);
         tick();
      end
      wr_s = 1'b0;
      chk("pre-areset count", 32'(count_s), 32'd3);
      #2 reset = 1'b1;
      #1;
      check_std("async reset", mk(1'b0, 1'b0, 16'h0, 16'h0, 0, 1'b0, 1'b0));
      #5 reset = 1'b0;

      // Reset after 5 writes and 2 reads; no stale data afterwards.
      for (int i = 0; i < 7; i++) begin
         wr_s  = (i < 5);
         rd_s  = (i >= 5);
         din_s = 16'h0041 + 16'(i);
         tick();
      end
      {wr_s, rd_s} = '0;
      chk("midop pre count", 32'(count_s), 32'd3);
      chk("midop pre dout", 32'(dout_s), 32'h0042);
      reset = 1'b1;
      #2 reset = 1'b0;
      chk("midop reset count", 32'(count_s), 32'd0);
      chk("midop reset empty", 32'(empty_s), 32'd1);
      wr_s  = 1'b1;
      din_s = 16'h00AA;
      tick();
      wr_s = 1'b0;
      rd_s = 1'b1;
      tick();
      rd_s = 1'b0;
      check_std("midop readback", mk(1'b0, 1'b1, 16'h0, 16'h00AA, 0, 1'b0, 1'b0));

      // FWFT: head visible right after the write edge, rd_en pops it.
      wr_f  = 1'b1;
      din_f = 16'h0001;
      tick();
      wr_f = 1'b0;
      chk("fwft dout", 32'(dout_f), 32'h0001);
      chk("fwft empty", 32'(empty_f), 32'd0);
      chk("fwft count", 32'(count_f), 32'd1);
      rd_f = 1'b1;
      tick();
      rd_f = 1'b0;
      chk("fwft pop empty", 32'(empty_f), 32'd1);
      chk("fwft pop unf", 32'(un_f), 32'd0);
      wr_f  = 1'b1;
      din_f = 16'h000A;
      tick();
      chk("fwft head A", 32'(dout_f), 32'h000A);
      din_f = 16'h000B;
      tick();
      wr_f = 1'b0;
      chk("fwft head still A", 32'(dout_f), 32'h000A);
      chk("fwft count2", 32'(count_f), 32'd2);
      rd_f = 1'b1;
      tick();
      rd_f = 1'b0;
      chk("fwft head B", 32'(dout_f), 32'h000B);
      chk("fwft count1", 32'(count_f), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
